// File: rtl/morph_pass_ctrl.sv
// morph_pass_ctrl: sequences a two-pass morphological opening (erode, then dilate)
// over a frame buffer pair. Walks interior rows column by column, inserts an idle
// gap between rows, then drains the engine write pipeline before switching
// passes or finishing.
module morph_pass_ctrl #(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int LAT        = 2,
  parameter int GAP        = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       mode,
  output logic       rd_en,
  output logic [9:0] rd_row,
  output logic [9:0] rd_col,
  output logic       rd_buf,
  output logic       wr_buf,
  output logic       eng_valid,
  output logic       wr_en,
  output logic [9:0] wr_row,
  output logic [9:0] wr_col
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ROW   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int         DEPTH    = LAT + 1;
  localparam logic [9:0] LAST_COL = 10'(PIC_WIDTH - 1);
  localparam logic [9:0] LAST_ROW = 10'(PIC_HEIGHT - 2);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  logic [2:0]       state;
  logic             pass;
  logic [3:0]       gap_cnt;
  logic [DEPTH-1:0] pipe_vld;
  logic [9:0]       pipe_row [DEPTH];
  logic [9:0]       pipe_col [DEPTH];
  logic             pipe_empty;
  logic             wr_issue;

  // A fetched column c>=2 completes the window centred on column c-1.
  assign pipe_empty = ~|pipe_vld;
  assign wr_issue   = rd_en && (rd_col >= 10'd2);

  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);
  assign rd_en  = (state == S_ROW);
  assign mode   = pass;
  assign rd_buf = pass;
  assign wr_buf = busy & ~pass;
  assign wr_en  = pipe_vld[DEPTH-1];
  assign wr_row = pipe_row[DEPTH-1];
  assign wr_col = pipe_col[DEPTH-1];

  // Pass sequencer: row walk, inter-row gap, drain, pass switch and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pass    <= 1'b0;
      rd_row  <= 10'd0;
      rd_col  <= 10'd0;
      gap_cnt <= 4'd0;
    end else if (abort) begin
      state   <= S_IDLE;
      pass    <= 1'b0;
      gap_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ROW;
            pass   <= 1'b0;
            rd_row <= 10'd1;
            rd_col <= 10'd0;
          end
        end
        S_ROW: begin
          if (rd_col == LAST_COL) begin
            state   <= S_GAP;
            gap_cnt <= 4'd0;
          end else begin
            rd_col <= rd_col + 10'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (rd_row == LAST_ROW) begin
              state <= S_DRAIN;
            end else begin
              state  <= S_ROW;
              rd_row <= rd_row + 10'd1;
              rd_col <= 10'd0;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (pipe_empty) begin
            if (!pass) begin
              state  <= S_ROW;
              pass   <= 1'b1;
              rd_row <= 10'd1;
              rd_col <= 10'd0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          pass  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The engine sees each fetched column one cycle after the fetch request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eng_valid <= 1'b0;
    else        eng_valid <= rd_en;
  end

  // Write pipeline: carries valid/row/col alongside the fetch and engine latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pipe_row[i] <= 10'd0;
        pipe_col[i] <= 10'd0;
      end
    end else if (abort) begin
      pipe_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pipe_row[i] <= 10'd0;
        pipe_col[i] <= 10'd0;
      end
    end else begin
      pipe_vld[0] <= wr_issue;
      pipe_row[0] <= rd_row;
      pipe_col[0] <= rd_col - 10'd1;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_row[i] <= pipe_row[i-1];
        pipe_col[i] <= pipe_col[i-1];
      end
    end
  end

endmodule

// File: tb/tb_morph_pass_ctrl.sv
// tb_morph_pass_ctrl: scoreboard bench for the opening pass controller.
// A small image instance gets full timing/coordinate checking; a default-size
// instance runs one pass concurrently for write count and border coverage.
module tb_morph_pass_ctrl;

  localparam int W = 6;
  localparam int H = 4;
  localparam int L = 2;
  localparam int G = 2;

  typedef struct {
    int cyc;
    int row;
    int col;
    int mode;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, mode, rd_en, rd_buf, wr_buf, eng_valid, wr_en;
  logic [9:0] rd_row, rd_col, wr_row, wr_col;

  logic       rst_n_b = 1'b0;
  logic       start_b = 1'b0;
  logic       abort_b = 1'b0;
  logic       busy_b, done_b, mode_b, rd_en_b, rd_buf_b, wr_buf_b, eng_valid_b, wr_en_b;
  logic [9:0] rd_row_b, rd_col_b, wr_row_b, wr_col_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  logic prev_rd_en = 1'b0;
  exp_t expq[$];
  int   doneq[$];

  morph_pass_ctrl #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .LAT(L), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .mode(mode), .rd_en(rd_en),
    .rd_row(rd_row), .rd_col(rd_col), .rd_buf(rd_buf), .wr_buf(wr_buf),
    .eng_valid(eng_valid), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col)
  );

  morph_pass_ctrl dut_big (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .mode(mode_b), .rd_en(rd_en_b),
    .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_buf(rd_buf_b), .wr_buf(wr_buf_b),
    .eng_valid(eng_valid_b), .wr_en(wr_en_b), .wr_row(wr_row_b), .wr_col(wr_col_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle index: the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reference model: both passes visit interior rows; every interior pixel is
  // written 1+L cycles after the fetch of the column to its right.
  task automatic scheduleRun(input int p0, output int done_cyc, output int p1, output int fifth_p1);
    exp_t e;
    int   p, rl, e_cyc, n1;
    p  = p0;
    n1 = 0;
    p1 = 0;
    fifth_p1 = 0;
    for (int ps = 0; ps < 2; ps++) begin
      if (ps == 1) p1 = p;
      for (int i = 0; i < H - 2; i++) begin
        for (int c = 2; c < W; c++) begin
          e.cyc  = p + i * (W + G) + c + 1 + L;
          e.row  = i + 1;
          e.col  = c - 1;
          e.mode = ps;
          expq.push_back(e);
          if (ps == 1) begin
            n1++;
            if (n1 == 5) fifth_p1 = e.cyc;
          end
        end
      end
      rl    = p + (H - 3) * (W + G);
      e_cyc = (rl + W + G > rl + W + L + 1) ? rl + W + G : rl + W + L + 1;
      p     = e_cyc + 1;
    end
    done_cyc = p;
    doneq.push_back(done_cyc);
  endtask

  task automatic applyStimulus(output int p0, output int done_cyc, output int p1, output int fifth_p1);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    start = 1'b1;
    p0 = cyc + 1;
    scheduleRun(p0, done_cyc, p1, fifth_p1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_flags"}, 32'({busy, done, mode, rd_en, eng_valid, wr_en, rd_buf, wr_buf}), 0);
    checkOutput({name, "_rd_coord"}, 32'({rd_row, rd_col}), 0);
    checkOutput({name, "_wr_coord"}, 32'({wr_row, wr_col}), 0);
  endtask

  // Monitor: pops the scoreboard on every write and done pulse, flags extras and misses.
  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      checkOutput("write_missing", 0, 1);
    end
    while (doneq.size() > 0 && doneq[0] < cyc) begin
      void'(doneq.pop_front());
      checkOutput("done_missing", 0, 1);
    end
    if (wr_en) begin
      wr_cnt++;
      if (expq.size() == 0) begin
        checkOutput("write_unexpected", 1, 0);
      end else begin
        e = expq.pop_front();
        checkOutput("wr_cycle", cyc, e.cyc);
        checkOutput("wr_row", 32'(wr_row), e.row);
        checkOutput("wr_col", 32'(wr_col), e.col);
        checkOutput("wr_mode", 32'(mode), e.mode);
        checkOutput("wr_buf", 32'(wr_buf), (e.mode == 0) ? 1 : 0);
      end
    end
    if (done) begin
      done_cnt++;
      if (doneq.size() == 0) checkOutput("done_unexpected", 1, 0);
      else                   checkOutput("done_cycle", cyc, doneq.pop_front());
    end
    if (rst_n) begin
      checkOutput("eng_valid_delay", 32'(eng_valid), 32'(prev_rd_en));
      prev_rd_en = rd_en;
    end else begin
      prev_rd_en = 1'b0;
    end
  end

  task automatic smallTests();
    int p0, dc, p1, f5, w0, d0, r;
    exp_t e;

    // Reset state
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Run 1: full opening, spurious starts while busy
    w0 = wr_cnt;
    d0 = done_cnt;
    applyStimulus(p0, dc, p1, f5);
    checkOutput("p0_busy", 32'(busy), 1);
    checkOutput("p0_mode", 32'(mode), 0);
    checkOutput("p0_rd_buf", 32'(rd_buf), 0);
    checkOutput("p0_wr_buf", 32'(wr_buf), 1);
    checkOutput("p0_rd_pos", 32'({rd_en, rd_row, rd_col}), 32'({1'b1, 10'd1, 10'd0}));
    waitCycle(p0 + 2);
    checkOutput("p0_rd_col2", 32'({rd_en, rd_row, rd_col}), 32'({1'b1, 10'd1, 10'd2}));
    waitCycle(p0 + 3);
    pulseStart();
    waitCycle(p1);
    checkOutput("p1_mode", 32'(mode), 1);
    checkOutput("p1_rd_buf", 32'(rd_buf), 1);
    checkOutput("p1_wr_buf", 32'(wr_buf), 0);
    checkOutput("p1_rd_pos", 32'({rd_en, rd_row, rd_col}), 32'({1'b1, 10'd1, 10'd0}));
    r = $urandom_range(p1 + 1, dc);
    waitCycle(r);
    pulseStart();
    waitCycle(dc + 3);
    checkOutput("run1_writes", wr_cnt - w0, 2 * (H - 2) * (W - 2));
    checkOutput("run1_done", done_cnt - d0, 1);
    checkOutput("run1_idle", 32'(busy), 0);

    // Start and abort together in IDLE
    w0 = wr_cnt;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_idle", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("start_abort_still_idle", 32'(busy), 0);
    checkOutput("start_abort_writes", wr_cnt - w0, 0);

    // Run 2: abort on the fifth write of pass 1
    d0 = done_cnt;
    applyStimulus(p0, dc, p1, f5);
    waitCycle(f5);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    while (expq.size() > 0 && expq[$].cyc > f5) e = expq.pop_back();
    doneq.delete();
    checkOutput("abort_idle", 32'(busy), 0);
    checkOutput("abort_wr_en", 32'(wr_en), 0);
    w0 = wr_cnt;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_writes", wr_cnt - w0, 0);
    checkOutput("abort_no_done", done_cnt - d0, 0);

    // Run 3: reset dropped in a GAP cycle
    applyStimulus(p0, dc, p1, f5);
    waitCycle(p0 + W);
    checkOutput("gap_rd_en", 32'(rd_en), 0);
    rst_n = 1'b0;
    #1;
    checkAllZero("gap_reset");
    while (expq.size() > 0 && expq[$].cyc >= p0 + W) e = expq.pop_back();
    doneq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", 32'(busy), 0);
    checkOutput("post_reset_writes", wr_cnt - w0, 0);

    // Run 4: full sequence after reset recovery
    d0 = done_cnt;
    applyStimulus(p0, dc, p1, f5);
    waitCycle(dc + 3);
    checkOutput("run4_writes", wr_cnt - w0, 2 * (H - 2) * (W - 2));
    checkOutput("run4_done", done_cnt - d0, 1);
    checkOutput("pending_writes", expq.size(), 0);
    checkOutput("pending_done", doneq.size(), 0);
  endtask

  task automatic bigTest();
    int   cnt;
    logic seen;
    logic border;
    cnt  = 0;
    seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int k = 0; k < 70000 && !seen; k++) begin
      @(negedge clk);
      if (wr_en_b) begin
        if (!mode_b) cnt++;
        border = (wr_row_b == 10'd0) || (wr_row_b == 10'd249) ||
                 (wr_col_b == 10'd0) || (wr_col_b == 10'd249);
        checkOutput("big_border", 32'(border), 0);
      end
      if (mode_b) seen = 1'b1;
    end
    checkOutput("big_pass1_reached", 32'(seen), 1);
    checkOutput("big_pass0_writes", cnt, 248 * 248);
    @(posedge clk);
    #1;
    abort_b = 1'b1;
    @(posedge clk);
    #1;
    abort_b = 1'b0;
    checkOutput("big_abort_idle", 32'(busy_b), 0);
  endtask

  initial begin
    fork
      smallTests();
      bigTest();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
